// File: rtl/kypd_pkg.sv
// kypd_pkg: shared definitions for the PmodKYPD scan controller.
//   KYPD_COLS / KYPD_ROWS : matrix dimensions
//   scan_state_t          : scan FSM states
//   KEYMAP[col][row]      : hex code of the key at column/row (index 0 = column/row 1)
package kypd_pkg;

    localparam int KYPD_COLS = 4;
    localparam int KYPD_ROWS = 4;

    typedef enum logic [1:0] {
        IDLE,
        DRIVE,
        SAMPLE
    } scan_state_t;

    localparam logic [3:0] KEYMAP [KYPD_COLS][KYPD_ROWS] = '{
        '{4'h1, 4'h4, 4'h7, 4'h0},
        '{4'h2, 4'h5, 4'h8, 4'hF},
        '{4'h3, 4'h6, 4'h9, 4'hE},
        '{4'hA, 4'hB, 4'hC, 4'hD}
    };

endpackage

// File: rtl/kypd_event_fifo.sv
// kypd_event_fifo: synchronous FIFO of 4-bit key codes.
//   clk, rst_n  : clock, synchronous active-low reset
//   push, push_data, full : write side; a push while full is ignored
//                           unless a pop happens in the same cycle
//   valid, data, ready    : read side; head pops when valid && ready
// No fall-through: a push onto an empty FIFO shows valid the next cycle.
module kypd_event_fifo #(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       push,
    input  logic [3:0] push_data,
    output logic       full,
    output logic       valid,
    output logic [3:0] data,
    input  logic       ready
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [3:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          pop;
    logic          do_push;

    assign valid   = (count != '0);
    assign full    = (count == FULL_CNT);
    assign data    = mem[rd_ptr];
    assign pop     = valid & ready;
    // A pop frees the slot in the same cycle, so full+pop still accepts a push.
    assign do_push = push & (~full | pop);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/kypd_scan_ctrl.sv
// kypd_scan_ctrl: 4x4 PmodKYPD scanner with per-key debounce and press FIFO.
//   clk, rst_n : clock, synchronous active-low reset
//   col_n      : active-low one-cold column strobes (bit 3 = column 1)
//   row_n      : active-low asynchronous row returns (bit 3 = row 1)
//   key_valid, key_code, key_ready : press-event stream (valid/ready)
//   key_down   : debounced pressed bitmap indexed by key code
//   overflow   : one-cycle pulse when a press event is dropped (FIFO full)
module kypd_scan_ctrl
    import kypd_pkg::*;
#(
    parameter int SETTLE_CYC     = 1000,
    parameter int DEBOUNCE_SCANS = 4,
    parameter int FIFO_DEPTH     = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [3:0]  col_n,
    input  logic [3:0]  row_n,
    output logic        key_valid,
    output logic [3:0]  key_code,
    input  logic        key_ready,
    output logic [15:0] key_down,
    output logic        overflow
);

    localparam int SW = $clog2(SETTLE_CYC);
    localparam int CW = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYC - 1);
    localparam logic [CW-1:0] DB_LAST     = CW'(DEBOUNCE_SCANS - 1);

    scan_state_t   state;
    logic [1:0]    col_idx;
    logic [1:0]    row_idx;
    logic [SW-1:0] settle_cnt;

    logic [3:0]    row_meta;
    logic [3:0]    row_sync;

    logic [CW-1:0] cnt [16];
    logic [3:0]    cur_key;
    logic          row_hit;
    logic          push_q;
    logic [3:0]    push_code;
    logic          fifo_full;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            row_meta <= '1;
            row_sync <= '1;
        end else begin
            row_meta <= row_n;
            row_sync <= row_meta;
        end
    end

    // Scan FSM. col_n is registered from the current state and column, so it
    // trails the state by one cycle; the lag is the same at every column
    // change, and the SAMPLE window still sees the column that was settled.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            col_idx    <= '0;
            row_idx    <= '0;
            settle_cnt <= '0;
            col_n      <= '1;
        end else begin
            col_n <= (state == IDLE) ? 4'b1111 : ~(4'b1000 >> col_idx);
            case (state)
                IDLE: begin
                    state      <= DRIVE;
                    col_idx    <= '0;
                    settle_cnt <= '0;
                end
                DRIVE: begin
                    if (settle_cnt == SETTLE_LAST) begin
                        state      <= SAMPLE;
                        row_idx    <= '0;
                        settle_cnt <= '0;
                    end else begin
                        settle_cnt <= settle_cnt + SW'(1);
                    end
                end
                SAMPLE: begin
                    if (row_idx == 2'd3) begin
                        state   <= DRIVE;
                        col_idx <= col_idx + 2'd1;
                    end else begin
                        row_idx <= row_idx + 2'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Row r lives at bit 3-r, which for a 2-bit index is simply ~r.
    assign cur_key = KEYMAP[col_idx][row_idx];
    assign row_hit = ~row_sync[~row_idx];

    // Per-key debounce; one key is visited per SAMPLE cycle, so at most one
    // press event is raised per cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            key_down  <= '0;
            push_q    <= 1'b0;
            push_code <= '0;
            for (int unsigned k = 0; k < 16; k++) begin
                cnt[k] <= '0;
            end
        end else begin
            push_q <= 1'b0;
            if (state == SAMPLE) begin
                if (row_hit == key_down[cur_key]) begin
                    cnt[cur_key] <= '0;
                end else if (cnt[cur_key] == DB_LAST) begin
                    key_down[cur_key] <= ~key_down[cur_key];
                    cnt[cur_key]      <= '0;
                    if (row_hit) begin
                        push_q    <= 1'b1;
                        push_code <= cur_key;
                    end
                end else begin
                    cnt[cur_key] <= cnt[cur_key] + CW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            overflow <= 1'b0;
        end else begin
            overflow <= push_q & fifo_full & ~(key_valid & key_ready);
        end
    end

    kypd_event_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push_q),
        .push_data (push_code),
        .full      (fifo_full),
        .valid     (key_valid),
        .data      (key_code),
        .ready     (key_ready)
    );

endmodule

// File: tb/tb_kypd_scan_ctrl.sv
// tb_kypd_scan_ctrl: directed bench for kypd_scan_ctrl with a behavioural
// keypad matrix (pressed keys short their row to the driven column).
module tb_kypd_scan_ctrl;

    localparam int SETTLE = 8;
    localparam int DEB    = 2;
    localparam int P      = 4 * (SETTLE + 4);

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  col_n;
    logic [3:0]  row_n;
    logic        key_valid;
    logic [3:0]  key_code;
    logic        key_ready;
    logic [15:0] key_down;
    logic        overflow;

    int total = 0;
    int bad   = 0;

    logic [15:0] pressed = '0;
    int km [4][4] = '{'{1, 4, 7, 0}, '{2, 5, 8, 15}, '{3, 6, 9, 14}, '{10, 11, 12, 13}};

    logic [3:0] popq [$];
    int ovf_cnt = 0;

    always #5 clk = ~clk;

    kypd_scan_ctrl #(
        .SETTLE_CYC     (SETTLE),
        .DEBOUNCE_SCANS (DEB),
        .FIFO_DEPTH     (4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .col_n     (col_n),
        .row_n     (row_n),
        .key_valid (key_valid),
        .key_code  (key_code),
        .key_ready (key_ready),
        .key_down  (key_down),
        .overflow  (overflow)
    );

    always_comb begin
        row_n = '1;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                if (col_n[3-c] == 1'b0 && pressed[km[c][r]]) row_n[3-r] = 1'b0;
            end
        end
    end

    always @(posedge clk) begin
        if (rst_n === 1'b1) begin
            if (key_valid && key_ready) popq.push_back(key_code);
            if (overflow) ovf_cnt++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_kd(input string tag, input int k, input logic lvl, input int lim);
        int i = 0;
        while (key_down[k] !== lvl && i < lim) begin
            @(negedge clk);
            i++;
        end
        chk(tag, 32'(key_down[k]), 32'(lvl));
    endtask

    task automatic wait_col(input string tag, input logic [3:0] v, input int lim);
        int i = 0;
        while (col_n !== v && i < lim) begin
            @(negedge clk);
            i++;
        end
        chk(tag, 32'(col_n), 32'(v));
    endtask

    task automatic pop_chk(input string tag, input logic [3:0] exp);
        chk({tag, "_valid"}, 32'(key_valid), 1);
        chk({tag, "_code"}, 32'(key_code), 32'(exp));
        key_ready = 1'b1;
        @(negedge clk);
        key_ready = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $display("test done: total=%0d bad=%0d", total, bad + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] e;
        int         i;
        logic       seen;
        int         ov_keys [5] = '{1, 2, 3, 5, 9};

        rst_n     = 1'b0;
        key_ready = 1'b0;

        // 1: reset values and column sequence
        cyc(5);
        chk("rst_col", 32'(col_n), 32'hF);
        chk("rst_valid", 32'(key_valid), 0);
        chk("rst_code", 32'(key_code), 0);
        chk("rst_down", 32'(key_down), 0);
        chk("rst_ovf", 32'(overflow), 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("col_first_idle", 32'(col_n), 32'hF);
        for (int c = 0; c < 5; c++) begin
            e = 4'b1000 >> (c % 4);
            e = ~e;
            for (int j = 0; j < 12; j++) begin
                @(negedge clk);
                if (j == 0 || j == 11) chk($sformatf("col%0d_cyc%0d", c, j), 32'(col_n), 32'(e));
            end
        end

        // 2: single press of key 6
        key_ready = 1'b1;
        popq.delete();
        pressed[6] = 1'b1;
        i = 0;
        while (!key_down[6] && i < 3 * P) begin
            @(negedge clk);
            i++;
        end
        chk("p6_down", 32'(key_down[6]), 1);
        chk("p6_latency", 32'(i >= P && i <= 2 * P + 4), 1);
        chk("p6_valid_lag", 32'(key_valid), 0);
        @(negedge clk);
        chk("p6_valid", 32'(key_valid), 1);
        chk("p6_code", 32'(key_code), 6);
        @(negedge clk);
        chk("p6_valid_pulse", 32'(key_valid), 0);
        pressed[6] = 1'b0;
        wait_kd("p6_release", 6, 1'b0, 3 * P);
        cyc(P);
        chk("p6_events", 32'(popq.size()), 1);
        chk("p6_evcode", (popq.size() > 0) ? 32'(popq[0]) : 32'hFF, 6);

        // 3: two single-scan bounces on key 1, separated by a clean scan
        popq.delete();
        seen = 1'b0;
        for (int b = 0; b < 2; b++) begin
            wait_col($sformatf("bounce%0d_align", b), 4'b0111, P);
            pressed[1] = 1'b1;
            for (int j = 0; j < 20; j++) begin
                @(negedge clk);
                if (key_down != '0) seen = 1'b1;
            end
            pressed[1] = 1'b0;
            for (int j = 0; j < P; j++) begin
                @(negedge clk);
                if (key_down != '0) seen = 1'b1;
            end
        end
        for (int j = 0; j < 3 * P; j++) begin
            @(negedge clk);
            if (key_down != '0) seen = 1'b1;
        end
        chk("bounce_down", 32'(seen), 0);
        chk("bounce_events", 32'(popq.size()), 0);

        // 4: simultaneous A, D (column 4) and 8 (column 2), pressed while column 4 is driven
        key_ready = 1'b0;
        ovf_cnt   = 0;
        wait_col("multi_align", 4'b1110, P);
        pressed[10] = 1'b1;
        pressed[13] = 1'b1;
        pressed[8]  = 1'b1;
        cyc(3 * P);
        chk("multi_down", 32'(key_down), 32'h2500);
        chk("multi_head", 32'(key_code), 32'hA);
        cyc(5);
        chk("multi_hold", 32'(key_code), 32'hA);
        pop_chk("multi_pop0", 4'hA);
        pop_chk("multi_pop1", 4'hD);
        pop_chk("multi_pop2", 4'h8);
        chk("multi_empty", 32'(key_valid), 0);
        chk("multi_ovf", 32'(ovf_cnt), 0);
        pressed = '0;
        wait_kd("multi_relA", 10, 1'b0, 3 * P);
        wait_kd("multi_relD", 13, 1'b0, 3 * P);
        wait_kd("multi_rel8", 8, 1'b0, 3 * P);

        // 5: overflow with five presses and no consumer
        ovf_cnt = 0;
        popq.delete();
        for (int k = 0; k < 5; k++) begin
            pressed[ov_keys[k]] = 1'b1;
            wait_kd($sformatf("ovf_press%0d", k), ov_keys[k], 1'b1, 3 * P);
            cyc(4);
            if (k == 3) chk("ovf_none_yet", 32'(ovf_cnt), 0);
        end
        chk("ovf_pulse", 32'(ovf_cnt), 1);
        chk("ovf_down", 32'(key_down), 32'h022E);
        chk("ovf_head", 32'(key_code), 1);
        key_ready = 1'b1;
        cyc(10);
        key_ready = 1'b0;
        chk("ovf_drained", 32'(popq.size()), 4);
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("ovf_order%0d", k), (popq.size() > k) ? 32'(popq[k]) : 32'hFF, 32'(ov_keys[k]));
        end
        chk("ovf_empty", 32'(key_valid), 0);
        pressed = '0;
        for (int k = 0; k < 5; k++) begin
            wait_kd($sformatf("ovf_rel%0d", k), ov_keys[k], 1'b0, 3 * P);
        end

        // 6: reset during SAMPLE with two events queued
        pressed[1] = 1'b1;
        pressed[4] = 1'b1;
        wait_kd("mid_press1", 1, 1'b1, 3 * P);
        wait_kd("mid_press4", 4, 1'b1, 3 * P);
        cyc(4);
        chk("mid_valid", 32'(key_valid), 1);
        chk("mid_down", 32'(key_down), 32'h0012);
        i = 0;
        while (col_n == 4'b1011 && i < 20) begin
            @(negedge clk);
            i++;
        end
        wait_col("mid_align", 4'b1011, P);
        cyc(8);
        rst_n = 1'b0;
        @(negedge clk);
        chk("mid_rst_valid", 32'(key_valid), 0);
        chk("mid_rst_down", 32'(key_down), 0);
        chk("mid_rst_col", 32'(col_n), 32'hF);
        chk("mid_rst_code", 32'(key_code), 0);
        pressed = '0;
        cyc(2);
        rst_n = 1'b1;
        cyc(2);
        chk("mid_restart_col", 32'(col_n), 32'h7);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
